// File: rtl/serdes_link_pkg.sv
// Shared definitions for the link framer and the matching deserialize-side checker.
package serdes_link_pkg;

    // Framer FSM states; encoding is shared with the checker.
    typedef enum logic [1:0] {
        ST_HEADER   = 2'd0,
        ST_PAYLOAD  = 2'd1,
        ST_CHECKSUM = 2'd2
    } frame_state_e;

    // Default start-of-frame marker and header field geometry.
    localparam logic [7:0] SOF_DEFAULT = 8'hA5;
    localparam int         SOF_W       = 8;
    localparam int         SEQ_LSB     = 0;

    // Bit position of the SOF marker within a word of the given width.
    function automatic int sof_lsb(input int bit_width);
        return bit_width - SOF_W;
    endfunction

endpackage

// File: rtl/serdes_link_framer_if.sv
// Val/rdy word channel; master drives msg/val, slave drives rdy.
interface serdes_link_framer_if #(
    parameter int BIT_WIDTH = 32
);
    logic [BIT_WIDTH-1:0] msg;
    logic                 val;
    logic                 rdy;

    modport master (output msg, output val, input rdy);
    modport slave  (input msg, input val, output rdy);
endinterface

// File: rtl/serdes_xor_accum.sv
// Running XOR accumulator; clear wins over enable so a frame boundary
// always restarts the checksum from zero.
module serdes_xor_accum #(
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic [BIT_WIDTH-1:0] d,
    output logic [BIT_WIDTH-1:0] q
);

    logic [BIT_WIDTH-1:0] acc_q;
    logic [BIT_WIDTH-1:0] acc_d;

    // Next accumulator value: clear, fold in d, or hold.
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q ^ d;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign q = acc_q;

endmodule

// File: rtl/serdes_link_framer.sv
// Frames serialized words: header (SOF + sequence), N_SAMPLES payload words
// passed straight through, then an XOR checksum of the payload.
module serdes_link_framer
    import serdes_link_pkg::*;
#(
    parameter int         BIT_WIDTH = 32,
    parameter int         N_SAMPLES = 8,
    parameter int         SEQ_WIDTH = 8,
    parameter logic [7:0] SOF_MARK  = SOF_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    serdes_link_framer_if.slave   recv,
    serdes_link_framer_if.master  send,
    output logic                  busy
);

    localparam int                CNT_W    = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_SAMPLES - 1);
    localparam int                SOF_LSB  = sof_lsb(BIT_WIDTH);

    frame_state_e         state_q;
    frame_state_e         state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [SEQ_WIDTH-1:0] seq_q;
    logic [SEQ_WIDTH-1:0] seq_d;

    logic [BIT_WIDTH-1:0] csum_s;
    logic [BIT_WIDTH-1:0] header_s;
    logic [BIT_WIDTH-1:0] send_msg_s;
    logic                 send_val_s;
    logic                 recv_rdy_s;
    logic                 busy_s;
    logic                 send_val_g_s;
    logic                 recv_rdy_g_s;
    logic                 up_xfer_s;
    logic                 down_xfer_s;
    logic                 acc_clr_s;

    // Outputs are forced idle while reset is held, whatever the FSM says.
    assign send_val_g_s = reset & send_val_s;
    assign recv_rdy_g_s = reset & recv_rdy_s;
    assign send.val     = send_val_g_s;
    assign send.msg     = send_msg_s;
    assign recv.rdy     = recv_rdy_g_s;
    assign busy         = reset & busy_s;

    assign up_xfer_s    = recv.val & recv_rdy_g_s;
    assign down_xfer_s  = send_val_g_s & send.rdy;
    assign acc_clr_s    = (state_q == ST_CHECKSUM) & down_xfer_s;

    // Payload checksum; only payload transfers are folded in, since
    // upstream is only ever accepted in PAYLOAD.
    serdes_xor_accum #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_csum (
        .clk   (clk),
        .rst_n (reset),
        .en    (up_xfer_s),
        .clr   (acc_clr_s),
        .d     (recv.msg),
        .q     (csum_s)
    );

    // Header word: SOF marker in the top byte, sequence number at the bottom.
    always_comb begin
        header_s                         = '0;
        header_s[SOF_LSB +: SOF_W]       = SOF_MARK;
        header_s[SEQ_LSB +: SEQ_WIDTH]   = seq_q;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_HEADER;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload counter and frame sequence registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            seq_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            seq_q <= seq_d;
        end
    end

    // Next-state, counter and sequence logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seq_d   = seq_q;
        case (state_q)
            ST_HEADER: begin
                if (down_xfer_s) begin
                    state_d = ST_PAYLOAD;
                end else begin
                    state_d = ST_HEADER;
                end
            end
            ST_PAYLOAD: begin
                if (up_xfer_s) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_CHECKSUM;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_PAYLOAD;
                    end
                end else begin
                    cnt_d   = cnt_q;
                    state_d = ST_PAYLOAD;
                end
            end
            ST_CHECKSUM: begin
                if (down_xfer_s) begin
                    seq_d   = seq_q + 1'b1;
                    state_d = ST_HEADER;
                end else begin
                    seq_d   = seq_q;
                    state_d = ST_CHECKSUM;
                end
            end
            default: begin
                state_d = ST_HEADER;
                cnt_d   = '0;
            end
        endcase
    end

    // Per-state output decode; payload is a combinational pass-through.
    always_comb begin
        send_msg_s = '0;
        send_val_s = 1'b0;
        recv_rdy_s = 1'b0;
        busy_s     = 1'b0;
        case (state_q)
            ST_HEADER: begin
                send_msg_s = header_s;
                send_val_s = recv.val;
            end
            ST_PAYLOAD: begin
                send_msg_s = recv.msg;
                send_val_s = recv.val;
                recv_rdy_s = send.rdy;
                busy_s     = 1'b1;
            end
            ST_CHECKSUM: begin
                send_msg_s = csum_s;
                send_val_s = 1'b1;
                busy_s     = 1'b1;
            end
            default: begin
                send_msg_s = '0;
                send_val_s = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/serdes_link_framer.md
Name: serdes_link_framer

Overview:
Sits between the serializer output and the link/deserializer input. Wraps each batch of N_SAMPLES serialized words into a frame:
- one header word (start-of-frame marker plus sequence number)
- N_SAMPLES payload words, passed through unchanged
- one trailing XOR checksum word

Val/rdy handshakes on both sides. Zero-latency pass-through during payload; the header and checksum words are inserted by stalling upstream.

Parameters:
BIT_WIDTH, 32, width of every word (payload, header, checksum)
N_SAMPLES, 8, payload words per frame; must be >= 2
SEQ_WIDTH, 8, width of the frame sequence counter; BIT_WIDTH >= 8 + SEQ_WIDTH
SOF_MARK, 8'hA5, 8-bit start-of-frame marker placed in header bits [BIT_WIDTH-1:BIT_WIDTH-8]

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset (asserted when 0)
recv_msg  input  BIT_WIDTH  payload word from serializer
recv_val  input  1  upstream word valid
recv_rdy  output  1  framer accepts upstream word
send_msg  output  BIT_WIDTH  framed word toward link
send_val  output  1  framed word valid
send_rdy  input  1  downstream ready
busy  output  1  high while a frame is in progress (state != HEADER)

Behaviour:
- Transfer definitions:
  - An upstream transfer occurs on a cycle with recv_val && recv_rdy.
  - A downstream transfer occurs on a cycle with send_val && send_rdy.
- FSM states: HEADER, PAYLOAD, CHECKSUM. Registers: state, cnt [$clog2(N_SAMPLES)-1:0], csum [BIT_WIDTH-1:0], seq [SEQ_WIDTH-1:0].
- Reset (reset==0, asynchronous):
  - state=HEADER, cnt=0, csum=0, seq=0.
  - While reset is asserted, send_val=0, recv_rdy=0 and busy=0, overriding the FSM.
- HEADER state:
  - send_val=recv_val; the header goes out only once the first payload word is waiting.
  - send_msg={SOF_MARK, zeros, seq}; recv_rdy=0.
  - On a downstream transfer -> PAYLOAD.
- PAYLOAD state:
  - send_msg=recv_msg, send_val=recv_val, recv_rdy=send_rdy (combinational, zero latency).
  - On each transfer: csum<=csum^recv_msg, cnt<=cnt+1.
  - When a transfer occurs with cnt==N_SAMPLES-1: cnt<=0, go to CHECKSUM.
- CHECKSUM state:
  - send_val=1, send_msg=csum, recv_rdy=0.
  - On a downstream transfer: csum<=0, seq<=seq+1 (wraps modulo 2^SEQ_WIDTH), go to HEADER.
- Stall rules:
  - send_msg and send_val stay stable while send_val && !send_rdy. The header and checksum are register-derived; payload stability is upstream's responsibility under val/rdy.
  - No word is duplicated or dropped.
- Gaps: recv_val=0 mid-payload drops send_val; csum and cnt hold.
- Throughput: N_SAMPLES+2 cycles per frame with continuous val/rdy. Back-to-back frames need no idle cycle (CHECKSUM -> HEADER -> header sent next cycle).
- Reset mid-frame aborts the frame without emitting a checksum; the next frame starts with seq=0 and csum=0.
- The checksum covers payload words only, seeded with 0; the header is excluded.
- busy=1 in PAYLOAD and CHECKSUM, 0 in HEADER.

Decomposition:
- Shared package serdes_link_pkg:
  - state enum (HEADER=2'd0, PAYLOAD=2'd1, CHECKSUM=2'd2)
  - SOF default 8'hA5
  - header field offsets (SOF_LSB = BIT_WIDTH-8, SEQ_LSB = 0)
  The deserialize-side checker imports the same package.
- One sub-module, serdes_xor_accum:
  - BIT_WIDTH register with async active-low reset
  - en and clr inputs, d input, q output; clr has priority over en
- The FSM and counters stay in the top module.

Test Plan:
All scenarios use BIT_WIDTH=32, N_SAMPLES=4, SEQ_WIDTH=8, SOF_MARK=8'hA5.
1. Words 1,2,3,4 with recv_val and send_rdy held high -> send_msg sequence 0xA5000000, 1, 2, 3, 4, 0x00000004 over 6 consecutive cycles; busy high for cycles 2-6.
2. Second frame 0x10,0x20,0x30,0x40 back-to-back -> header 0xA5000001, payload passed through, checksum 0x00000040, no idle cycle between frames.
3. send_rdy low for 3 cycles while the header is pending, then during word 2 and during the checksum -> outputs held stable, recv_rdy=0 while stalled; final stream identical to scenario 1.
4. Run 257 frames -> headers ...0xA50000FE, 0xA50000FF, 0xA5000000 (seq wrap).
5. reset driven low asynchronously after 2 payload words -> send_val and recv_rdy go 0 immediately. After release, frame 5,6,7,8 yields header 0xA5000000 and checksum 5^6^7^8=0x0000000C.
6. recv_val gaps (2 idle cycles) between payload words -> send_val low during the gaps, cnt holds, checksum still correct (1^2^3^4=4).
